fm_conj_mult: RTL
=================

FM_CONJ_MULT -- requirements
Module: fm_conj_mult

Interface
REQ-001 Parameter: DATA_WIDTH, 32, sample width (signed, two's complement).
REQ-002 Parameter: BITS, 10, quantization shift (1.0 = 2^BITS).
REQ-003 clock  in  1  sole clock; all state on rising edge.
REQ-004 reset  in  1  asynchronous, active-low reset (reset=0 resets).
REQ-005 inI_dout  in  DATA_WIDTH  signed in-phase sample at head of upstream FIFO (first-word-fall-through).
REQ-006 inI_empty  in  1  upstream in-phase FIFO empty.
REQ-007 inI_rd_en  out  1  pop in-phase FIFO.
REQ-008 inQ_dout  in  DATA_WIDTH  signed quadrature sample at head of upstream FIFO.
REQ-009 inQ_empty  in  1  upstream quadrature FIFO empty.
REQ-010 inQ_rd_en  out  1  pop quadrature FIFO.
REQ-011 R_din  out  DATA_WIDTH  signed real part of conjugate product, to downstream arctan R FIFO.
REQ-012 R_full  in  1  R FIFO full.
REQ-013 R_wr_en  out  1  write R FIFO.
REQ-014 I_din  out  DATA_WIDTH  signed imaginary part of conjugate product, to downstream arctan I FIFO.
REQ-015 I_full  in  1  I FIFO full.
REQ-016 I_wr_en  out  1  write I FIFO.

Function
REQ-017 FSM states S_READ, S_MULT, S_WRITE; registers cur_r, cur_i, prev_r, prev_i, R_din, I_din.
REQ-018 S_READ: when inI_empty=0 and inQ_empty=0 in the same cycle, assert inI_rd_en and inQ_rd_en together (combinationally), latch cur_r<=inI_dout, cur_i<=inQ_dout, go S_MULT; else stay, both rd_en 0.
REQ-019 Never pop one input FIFO without the other.
REQ-020 Define deq(x) = x arithmetic-shift-right BITS (floor) on the full 2*DATA_WIDTH product, truncated to low DATA_WIDTH bits.
REQ-021 S_MULT (one cycle): R_din <= deq(prev_r*cur_r) - deq(-prev_i*cur_i); I_din <= deq(prev_r*cur_i) + deq(-prev_i*cur_r); sums wrap modulo 2^DATA_WIDTH; go S_WRITE.
REQ-022 Negation precedes the shift in REQ-021 terms (deq(-x) is not -deq(x)); bit-exact match required.
REQ-023 S_WRITE: when R_full=0 and I_full=0, assert R_wr_en and I_wr_en together (combinationally), prev_r<=cur_r, prev_i<=cur_i, go S_READ; else stay, both wr_en 0, R_din/I_din held stable.
REQ-024 Never write one output FIFO without the other.
REQ-025 Latency: pop cycle to write cycle = 2 cycles minimum; throughput 1 sample per 3 cycles when unstalled.
REQ-026 First sample after reset uses prev=(0,0), producing R_din=0, I_din=0.
REQ-027 No input pop while in S_MULT or S_WRITE (no sample lost or reordered under backpressure).

Reset
REQ-028 While reset=0: state=S_READ; cur_r, cur_i, prev_r, prev_i, R_din, I_din = 0.
REQ-029 While reset=0: inI_rd_en, inQ_rd_en, R_wr_en, I_wr_en = 0 regardless of FIFO flags.
REQ-030 Reset asserted mid-operation discards the in-flight sample (not written) and clears prev; no partial write occurs.

Verification
REQ-031 After reset push (I,Q)=(1024,0) then (0,1024), outputs never full -> writes (R,I)=(0,0) then (0,1024).
REQ-032 Push (0,1) then (0,1) -> second write (R,I)=(1,0) (deq(-1)=-1 asymmetry check).
REQ-033 Hold R_full=1 after a sample reaches S_WRITE for 10 cycles -> R_wr_en=I_wr_en=0, R_din/I_din constant, no rd_en; release -> exactly one paired write next cycle.
REQ-034 inI_empty=0, inQ_empty=1 for 20 cycles -> no rd_en asserted, no writes; deassert inQ_empty -> paired pop within 1 cycle.
REQ-035 Push (1024,0), assert reset in S_MULT for 2 cycles, release, push (0,1024) -> only output (R,I)=(0,0); in-flight sample never written.
REQ-036 Random 1000-sample stream with random full/empty stalls vs bit-exact C model of REQ-021 -> all outputs match in order, count equal.

Source files
------------

// File: rtl/fm_conj_mult.sv
// Conjugate multiplier for an FM discriminator: computes cur * conj(prev) in fixed point.
// It pops a paired I/Q sample, multiplies for one cycle, then writes a paired R/I result.
module fm_conj_mult #(
  parameter int DATA_WIDTH = 32,
  parameter int BITS       = 10
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic [DATA_WIDTH-1:0] inI_dout,
  input  logic                  inI_empty,
  output logic                  inI_rd_en,
  input  logic [DATA_WIDTH-1:0] inQ_dout,
  input  logic                  inQ_empty,
  output logic                  inQ_rd_en,
  output logic [DATA_WIDTH-1:0] R_din,
  input  logic                  R_full,
  output logic                  R_wr_en,
  output logic [DATA_WIDTH-1:0] I_din,
  input  logic                  I_full,
  output logic                  I_wr_en
);

  localparam int PW = 2 * DATA_WIDTH;

  typedef enum logic [1:0] {StRead, StMult, StWrite} state_e;

  state_e                state_q, state_d;
  logic [DATA_WIDTH-1:0] cur_r_q, cur_i_q, prev_r_q, prev_i_q;
  logic                  rd_go, wr_go;
  logic signed [PW-1:0]  p_rr, p_ii, p_ri, p_ir;
  logic [DATA_WIDTH-1:0] r_next, i_next;

  function automatic logic signed [PW-1:0] sext(input logic [DATA_WIDTH-1:0] x);
    return {{DATA_WIDTH{x[DATA_WIDTH-1]}}, x};
  endfunction

  // Floor shift of the full-width product, keeping only the low word.
  function automatic logic [DATA_WIDTH-1:0] deq(input logic signed [PW-1:0] x);
    return DATA_WIDTH'(x >>> BITS);
  endfunction

  assign p_rr = sext(prev_r_q) * sext(cur_r_q);
  assign p_ii = sext(prev_i_q) * sext(cur_i_q);
  assign p_ri = sext(prev_r_q) * sext(cur_i_q);
  assign p_ir = sext(prev_i_q) * sext(cur_r_q);

  // Negate before shifting: floor(-x) differs from -floor(x) for inexact products.
  assign r_next = deq(p_rr) - deq(-p_ii);
  assign i_next = deq(p_ri) + deq(-p_ir);

  always_comb begin
    state_d = state_q;
    rd_go   = 1'b0;
    wr_go   = 1'b0;
    unique case (state_q)
      StRead: begin
        // Both FIFOs must have data so the I and Q streams never slip.
        if (reset && !inI_empty && !inQ_empty) begin
          rd_go   = 1'b1;
          state_d = StMult;
        end
      end
      StMult: state_d = StWrite;
      StWrite: begin
        if (reset && !R_full && !I_full) begin
          wr_go   = 1'b1;
          state_d = StRead;
        end
      end
      default: state_d = StRead;
    endcase
  end

  assign inI_rd_en = rd_go;
  assign inQ_rd_en = rd_go;
  assign R_wr_en   = wr_go;
  assign I_wr_en   = wr_go;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q  <= StRead;
      cur_r_q  <= '0;
      cur_i_q  <= '0;
      prev_r_q <= '0;
      prev_i_q <= '0;
      R_din    <= '0;
      I_din    <= '0;
    end else begin
      state_q <= state_d;
      if (rd_go) begin
        cur_r_q <= inI_dout;
        cur_i_q <= inQ_dout;
      end
      if (state_q == StMult) begin
        R_din <= r_next;
        I_din <= i_next;
      end
      // prev only advances once the result has actually left the block.
      if (wr_go) begin
        prev_r_q <= cur_r_q;
        prev_i_q <= cur_i_q;
      end
    end
  end

endmodule
